// File: rtl/alu_pkg.sv
// Shared constants for the LABIII ALU: data width, opcode encodings and
// the position of the opcode field inside the instruction word.
package alu_pkg;

  localparam int ALU_W  = 32;
  localparam int OP_MSB = 31;
  localparam int OP_LSB = 27;

  localparam logic [4:0] OP_ADD = 5'h03;
  localparam logic [4:0] OP_SUB = 5'h04;
  localparam logic [4:0] OP_MUL = 5'h05;
  localparam logic [4:0] OP_DIV = 5'h06;
  localparam logic [4:0] OP_AND = 5'h07;
  localparam logic [4:0] OP_OR  = 5'h08;
  localparam logic [4:0] OP_XOR = 5'h09;
  localparam logic [4:0] OP_NOT = 5'h0A;
  localparam logic [4:0] OP_SLL = 5'h0B;
  localparam logic [4:0] OP_SRL = 5'h0C;
  localparam logic [4:0] OP_CMP = 5'h0D;

endpackage

// File: rtl/alu_div.sv
// Combinational signed divider, truncating toward zero. Works on operand
// magnitudes so that 0x80000000 / -1 naturally yields 0x80000000.
module alu_div
  import alu_pkg::*;
(
  input  logic [ALU_W-1:0] dividend,
  input  logic [ALU_W-1:0] divisor,
  output logic [ALU_W-1:0] quotient,
  output logic             div_zero,
  output logic             ovf
);

  logic [ALU_W-1:0] mag_a, mag_b, mag_q;
  logic             neg;

  assign div_zero = (divisor == '0);
  assign neg      = dividend[ALU_W-1] ^ divisor[ALU_W-1];
  assign mag_a    = dividend[ALU_W-1] ? (~dividend + 1'b1) : dividend;
  assign mag_b    = divisor[ALU_W-1]  ? (~divisor + 1'b1)  : divisor;
  assign mag_q    = div_zero ? '0 : (mag_a / mag_b);
  assign quotient = div_zero ? '0 : (neg ? (~mag_q + 1'b1) : mag_q);

  // Only the most-negative value divided by -1 leaves the signed range.
  assign ovf = !div_zero && (dividend == {1'b1, {(ALU_W-1){1'b0}}}) && (divisor == '1);

endmodule

// File: rtl/proc_alu.sv
// Registered 32-bit ALU with compare/status flags, one cycle latency.
// Define ALU_DIV_EN to build the signed divider; otherwise DIV is illegal.
module proc_alu
  import alu_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [ALU_W-1:0] operand_a,
  input  logic [ALU_W-1:0] operand_b,
  input  logic [ALU_W-1:0] op_code,
  output logic [ALU_W-1:0] result,
  output logic             equal,
  output logic             above,
  output logic             below,
  output logic             overflow,
  output logic             error
);

  logic [4:0]         op;
  logic [ALU_W:0]     sum, diff;
  logic [2*ALU_W-1:0] prod;
  logic [ALU_W-1:0]   res_n;
  logic               ovf_n, err_n;

  assign op   = op_code[OP_MSB:OP_LSB];
  assign sum  = {1'b0, operand_a} + {1'b0, operand_b};
  assign diff = {1'b0, operand_a} - {1'b0, operand_b};
  assign prod = {{ALU_W{1'b0}}, operand_a} * {{ALU_W{1'b0}}, operand_b};

`ifdef ALU_DIV_EN
  logic [ALU_W-1:0] div_q;
  logic             div_zero, div_ovf;

  alu_div u_div (
    .dividend (operand_a),
    .divisor  (operand_b),
    .quotient (div_q),
    .div_zero (div_zero),
    .ovf      (div_ovf)
  );
`endif

  always_comb begin
    res_n = '0;
    ovf_n = 1'b0;
    err_n = 1'b0;
    case (op)
      OP_ADD: begin res_n = sum[ALU_W-1:0];  ovf_n = sum[ALU_W];  end
      OP_SUB: begin res_n = diff[ALU_W-1:0]; ovf_n = diff[ALU_W]; end
      OP_MUL: begin res_n = prod[ALU_W-1:0]; ovf_n = |prod[2*ALU_W-1:ALU_W]; end
`ifdef ALU_DIV_EN
      OP_DIV: begin res_n = div_q; ovf_n = div_ovf; err_n = div_zero; end
`endif
      OP_AND: res_n = operand_a & operand_b;
      OP_OR:  res_n = operand_a | operand_b;
      OP_XOR: res_n = operand_a ^ operand_b;
      OP_NOT: res_n = ~operand_a;
      OP_SLL: res_n = operand_a << operand_b[4:0];
      OP_SRL: res_n = operand_a >> operand_b[4:0];
      OP_CMP: res_n = '0;
      default: err_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result   <= '0;
      equal    <= 1'b0;
      above    <= 1'b0;
      below    <= 1'b0;
      overflow <= 1'b0;
      error    <= 1'b0;
    end else begin
      result   <= res_n;
      equal    <= (operand_a == operand_b);
      above    <= (operand_a >  operand_b);
      below    <= (operand_a <  operand_b);
      overflow <= ovf_n;
      error    <= err_n;
    end
  end

endmodule

// File: tb/tb_proc_alu.sv
// Self-checking bench for proc_alu: directed cases plus random operations
// compared against an arithmetic reference model.
module tb_proc_alu;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] operand_a, operand_b, op_code;
  logic [31:0] result;
  logic        equal, above, below, overflow, error;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] res;
    logic        eq, ab, bl, ovf, err;
  } exp_t;

`ifdef ALU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  proc_alu dut (
    .clk       (clk),
    .rst       (rst),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .op_code   (op_code),
    .result    (result),
    .equal     (equal),
    .above     (above),
    .below     (below),
    .overflow  (overflow),
    .error     (error)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic [4:0] op);
    exp_t        e;
    logic [63:0] w;
    longint      sa, sb, q;
    e.res = 32'h0; e.ovf = 1'b0; e.err = 1'b0;
    e.eq = (a == b); e.ab = (a > b); e.bl = (a < b);
    case (op)
      5'h03: begin w = 64'(a) + 64'(b); e.res = w[31:0]; e.ovf = (w > 64'hFFFF_FFFF); end
      5'h04: begin e.res = a - b; e.ovf = (a < b); end
      5'h05: begin w = 64'(a) * 64'(b); e.res = w[31:0]; e.ovf = (w > 64'hFFFF_FFFF); end
      5'h06: begin
        if (!DIV_EN || b == 32'h0) e.err = 1'b1;
        else begin
          sa = longint'($signed(a)); sb = longint'($signed(b));
          q = sa / sb;
          e.res = q[31:0];
          e.ovf = (q > 64'sd2147483647);
        end
      end
      5'h07: e.res = a & b;
      5'h08: e.res = a | b;
      5'h09: e.res = a ^ b;
      5'h0A: e.res = ~a;
      5'h0B: e.res = a << b[4:0];
      5'h0C: e.res = a >> b[4:0];
      5'h0D: e.res = 32'h0;
      default: e.err = 1'b1;
    endcase
    return e;
  endfunction

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Apply one operation, wait for the register, compare all outputs to the model.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b, input logic [31:0] word);
    exp_t e;
    operand_a = a; operand_b = b; op_code = word;
    e = model(a, b, word[31:27]);
    @(posedge clk); #1;
    chk32({tag, ".result"}, result, e.res);
    chk1({tag, ".equal"}, equal, e.eq);
    chk1({tag, ".above"}, above, e.ab);
    chk1({tag, ".below"}, below, e.bl);
    chk1({tag, ".overflow"}, overflow, e.ovf);
    chk1({tag, ".error"}, error, e.err);
  endtask

  function automatic logic [31:0] ins(input logic [4:0] op);
    return {op, 27'h0};
  endfunction

  initial begin
    logic [31:0] a, b;
    logic [4:0]  op;

    // Reset with a live ADD on the inputs: it must be discarded.
    rst = 1'b1; operand_a = 32'd5; operand_b = 32'd8; op_code = ins(5'h03);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      chk32("rst.result", result, 32'h0);
      chk1("rst.equal", equal, 1'b0);
      chk1("rst.above", above, 1'b0);
      chk1("rst.below", below, 1'b0);
      chk1("rst.overflow", overflow, 1'b0);
      chk1("rst.error", error, 1'b0);
    end
    rst = 1'b0;

    run_op("add_5_8", 32'd5, 32'd8, ins(5'h03));
    chk32("add_5_8.const", result, 32'd13);
    chk1("add_5_8.below_const", below, 1'b1);
    run_op("add_wrap", 32'hFFFF_FFFF, 32'd1, ins(5'h03));
    chk1("add_wrap.ovf_const", overflow, 1'b1);
    chk1("add_wrap.above_const", above, 1'b1);
    run_op("sub_10_3", 32'd10, 32'd3, ins(5'h04));
    chk32("sub_10_3.const", result, 32'd7);
    run_op("sub_borrow", 32'd1, 32'hFFFF_FFFF, ins(5'h04));
    chk32("sub_borrow.const", result, 32'd2);
    chk1("sub_borrow.ovf_const", overflow, 1'b1);
    run_op("mul_2_8", 32'd2, 32'd8, ins(5'h05));
    chk32("mul_2_8.const", result, 32'd16);
    run_op("mul_ovf", 32'd2, 32'hFFFF_FFFF, ins(5'h05));
    chk32("mul_ovf.const", result, 32'hFFFF_FFFE);
    chk1("mul_ovf.ovf_const", overflow, 1'b1);

    run_op("div_28_4", 32'd28, 32'd4, ins(5'h06));
`ifdef ALU_DIV_EN
    chk32("div_28_4.const", result, 32'd7);
    run_op("div_minint", 32'h8000_0000, 32'hFFFF_FFFF, ins(5'h06));
    chk32("div_minint.const", result, 32'h8000_0000);
    chk1("div_minint.ovf_const", overflow, 1'b1);
    run_op("div_neg", 32'hFFFF_FFF9, 32'd2, ins(5'h06));
    chk32("div_neg.const", result, 32'hFFFF_FFFD);
`else
    chk1("div_off.err_const", error, 1'b1);
    chk32("div_off.res_const", result, 32'h0);
`endif
    run_op("div_zero", 32'd5, 32'd0, ins(5'h06));
    chk1("div_zero.err_const", error, 1'b1);
    chk1("div_zero.ovf_const", overflow, 1'b0);

    run_op("and_word", 32'd1, 32'd1, 32'h3F38_A000);
    chk32("and_word.const", result, 32'd1);
    chk1("and_word.eq_const", equal, 1'b1);
    run_op("illegal_1f", 32'd3, 32'd4, ins(5'h1F));
    chk1("illegal_1f.err_const", error, 1'b1);
    run_op("illegal_00", 32'd7, 32'd7, ins(5'h00));
    run_op("cmp_9_9", 32'd9, 32'd9, ins(5'h0D));
    chk1("cmp_9_9.eq_const", equal, 1'b1);
    run_op("sll", 32'h8000_0001, 32'hFFFF_FFE4, ins(5'h0B));
    run_op("srl", 32'h8000_0001, 32'd31, ins(5'h0C));
    run_op("not", 32'h1234_5678, 32'hDEAD_BEEF, ins(5'h0A));

    // Hold inputs: registered outputs must not change.
    @(posedge clk); #1;
    chk32("hold.result", result, 32'hEDCB_A987);

    for (int i = 0; i < 300; i++) begin
      a  = $urandom;
      b  = ($urandom_range(0, 7) == 0) ? a : (($urandom_range(0, 9) == 0) ? 32'h0 : $urandom);
      op = ($urandom_range(0, 5) == 0) ? 5'($urandom) : 5'($urandom_range(3, 13));
      run_op("rand", a, b, {op, 27'($urandom)});
    end

    // Reset mid-stream clears the pipeline register.
    rst = 1'b1; operand_a = 32'hFFFF_FFFF; operand_b = 32'd1; op_code = ins(5'h03);
    @(posedge clk); #1;
    chk32("rst2.result", result, 32'h0);
    chk1("rst2.overflow", overflow, 1'b0);
    chk1("rst2.above", above, 1'b0);
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/proc_alu.md
# proc_alu

Registered 32-bit integer ALU for the LABIII processor datapath. It takes two operands and the full 32-bit instruction word, decodes the 5-bit opcode from `op_code[31:27]`, and produces a result plus comparison and status flags one clock after the inputs are sampled. The ALU sits between the register-file read ports and the write-back stage. Module name: `proc_alu`.

## Interface
- Parameters: none. The data width is fixed at 32 by the package constant `ALU_W`.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `operand_a` in 32: first operand (A).
- `operand_b` in 32: second operand (B).
- `op_code` in 32: full instruction word; only bits [31:27] are decoded, bits [26:0] are ignored.
- `result` out 32: registered operation result.
- `equal` out 1: registered flag, A == B.
- `above` out 1: registered flag, A > B (unsigned).
- `below` out 1: registered flag, A < B (unsigned).
- `overflow` out 1: registered; the operation result did not fit (see Operation).
- `error` out 1: registered; illegal opcode or divide by zero.

## Operation
Opcodes decoded from `op_code[31:27]`:
- 0x03 ADD: result = A+B mod 2^32. overflow = carry out of bit 31 (unsigned). Example: 0xFFFFFFFF+1 gives 0, overflow=1.
- 0x04 SUB: result = A−B mod 2^32. overflow = borrow (A < B unsigned). Example: 1−0xFFFFFFFF gives 2, overflow=1.
- 0x05 MUL: result = low 32 bits of the unsigned 64-bit product. overflow = 1 when the high 32 bits are nonzero.
- 0x06 DIV: signed division truncating toward zero; result = quotient.
  - 0x80000000 / 0xFFFFFFFF: result = 0x80000000, overflow=1.
  - B == 0: result = 0, error=1, overflow=0.
- 0x07 AND, 0x08 OR, 0x09 XOR: bitwise; overflow=0.
- 0x0A NOT: result = ~A; B is ignored.
- 0x0B SLL: A << B[4:0].
- 0x0C SRL: logical A >> B[4:0].
- 0x0D CMP: result = 0; only the flags are meaningful.
- Any other opcode: result = 0, overflow=0, error=1.
- `equal`, `above` and `below` are computed from A and B for every opcode, including illegal ones. Exactly one of the three is 1.
- `overflow` is 0 for every opcode except ADD, SUB, MUL and DIV.

## Timing
- Inputs are sampled on each rising `clk` edge. All outputs are registered and valid from that edge: latency 1 cycle, throughput 1 operation per cycle.
- There is no handshake; a new operation may be issued every cycle.
- While `rst`=1 at a rising edge, all outputs go to 0, including `result` and every flag. Reset takes priority over any operation presented in the same cycle.
- Outputs hold their value while the inputs are stable. An operation sampled in the same cycle as reset is discarded.
- The combinational path (including the 32x32 multiply and 32-bit divide) must close within one cycle.

## Configuration
- `ALU_DIV_EN` defined: DIV (0x06) is implemented as specified above.
- `ALU_DIV_EN` undefined: the divider logic is not built. Opcode 0x06 behaves as an illegal opcode: result=0, error=1, overflow=0.

## Structure
- Package `alu_pkg` holds:
  - `ALU_W` = 32;
  - opcode localparams `OP_ADD`..`OP_CMP` with the values listed in Operation;
  - the opcode field positions `OP_MSB` = 31 and `OP_LSB` = 27.
- One sub-module, `alu_div`: combinational signed 32-bit divider. It outputs the quotient, a divide-by-zero flag and an overflow flag. It is instantiated only under `ALU_DIV_EN`.

## Test plan
- Reset: hold `rst`=1 for 2 cycles with A=5, B=8 and ADD applied. All outputs must read 0.
- Addition:
  - ADD 5+8: result=13, overflow=0, below=1.
  - ADD 0xFFFFFFFF+1: result=0, overflow=1, above=1.
- Subtraction and multiply:
  - SUB 10−3: result=7, overflow=0.
  - SUB 1−0xFFFFFFFF: result=2, overflow=1.
  - MUL 2×8: result=16, overflow=0.
  - MUL 2×0xFFFFFFFF: result=0xFFFFFFFE, overflow=1.
- Division:
  - DIV 28/4: result=7.
  - DIV 0x80000000/0xFFFFFFFF: result=0x80000000, overflow=1.
  - DIV 5/0: result=0, error=1.
  - With `ALU_DIV_EN` undefined: DIV 28/4 gives error=1, result=0.
- Logic and illegal opcodes:
  - Instruction word 0x3F38A000 (opcode 0x07, AND) with A=1, B=1: result=1, equal=1, overflow=0.
  - Opcode 0x1F: result=0, error=1.
  - CMP with A=B=9: equal=1, result=0.
